// File: rtl/scan_pkg.sv
// Shared constants for the display scan path: default scan period,
// maximum supported digit count and the idle (all-off) anode pattern.
package scan_pkg;

  // 2 ms scan step at a 100 MHz system clock.
  localparam int SCAN_DIV_DEFAULT = 200000;

  // Widest display the scanner supports.
  localparam int SCAN_DIGITS_MAX = 16;

  // Anodes are active-low, so "all digits off" is all ones.
  localparam logic [SCAN_DIGITS_MAX-1:0] SCAN_ANODE_IDLE = 16'hFFFF;

endpackage

// File: rtl/anode_scanner_chk.sv
// Run-time invariants of the anode scanner outputs. Simulation only; a
// synthesis flow drops the assertions.
module anode_scanner_chk #(
  parameter int DIGITS = 8
) (
  input logic              clk,
  input logic              rst,
  input logic              en,
  input logic              tick,
  input logic              wrap,
  input logic [DIGITS-1:0] anode
);

  // At most one digit is driven at any time.
  a_one_cold: assert property (@(posedge clk) disable iff (!rst) $onehot0(~anode));

  // A wrap is always a special kind of tick.
  a_wrap_tick: assert property (@(posedge clk) disable iff (!rst) wrap |-> tick);

  // The timebase never ticks while counting is frozen.
  a_tick_en: assert property (@(posedge clk) disable iff (!rst) tick |-> en);

endmodule

// File: rtl/mask_next_idx.sv
// Cyclic priority search: starting one position after the current index and
// wrapping modulo DIGITS, return the first position whose mask bit is set.
// The search may land back on the current index, so a lone enabled digit
// selects itself. With an empty mask, found is low and the index is returned
// unchanged.
module mask_next_idx #(
  parameter int DIGITS = 8,
  parameter int IDX_W  = 3
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [DIGITS-1:0] mask,
  output logic [IDX_W-1:0]  next_idx,
  output logic              found
);

  int dist_s;
  int best_s;

  // Pick the enabled position with the smallest forward distance (1..DIGITS).
  always_comb begin
    next_idx = idx;
    found    = 1'b0;
    best_s   = DIGITS + 1;
    dist_s   = 0;
    for (int p = 0; p < DIGITS; p++) begin
      dist_s = p - int'(idx);
      if (dist_s <= 0) begin
        dist_s = dist_s + DIGITS;
      end else begin
        dist_s = dist_s;
      end
      if (mask[p] && (dist_s < best_s)) begin
        best_s   = dist_s;
        next_idx = IDX_W'(p);
        found    = 1'b1;
      end else begin
        best_s   = best_s;
      end
    end
  end

endmodule

// File: rtl/anode_scanner.sv
// Display-scan timebase and digit sequencer. A runtime-loadable prescaler
// produces a one-cycle tick every `per` enabled clocks; each tick moves the
// digit index to the next digit enabled in digit_mask, and the matching
// active-low anode is decoded combinationally so masking a digit blanks it
// at once.
module anode_scanner
  import scan_pkg::*;
#(
  parameter int DIV_DEFAULT = SCAN_DIV_DEFAULT,
  parameter int DIV_W       = 18,
  parameter int DIGITS      = 8,
  parameter int IDX_W       = ($clog2(DIGITS) > 0) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_value,
  input  logic [DIGITS-1:0] digit_mask,
  output logic              tick,
  output logic              wrap,
  output logic [IDX_W-1:0]  digit_idx,
  output logic [DIGITS-1:0] anode
);

  // DIV_W must be wide enough for DIV_DEFAULT; the cast below truncates.
  localparam logic [DIV_W-1:0] PER_RESET = DIV_W'(DIV_DEFAULT);

  logic [DIV_W-1:0]  per_r;
  logic [DIV_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [IDX_W-1:0]  next_idx_s;
  logic              found_s;
  logic              tick_s;
  logic              wrap_s;
  logic [DIGITS-1:0] anode_s;

  // Period register; a zero load is clamped to 1 (tick every enabled cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_r <= PER_RESET;
    end else if (div_load) begin
      per_r <= (div_value == '0) ? DIV_W'(1) : div_value;
    end else begin
      per_r <= per_r;
    end
  end

  // Terminal-count decode; a load in the same cycle suppresses a stale tick.
  always_comb begin
    tick_s = 1'b0;
    if (en && !div_load && (cnt_r == (per_r - DIV_W'(1)))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescale counter: load clears, tick clears, enable counts, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (div_load) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + DIV_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  mask_next_idx #(
    .DIGITS (DIGITS),
    .IDX_W  (IDX_W)
  ) u_next (
    .idx      (idx_r),
    .mask     (digit_mask),
    .next_idx (next_idx_s),
    .found    (found_s)
  );

  // Digit index advances on a tick; an empty mask leaves it where it is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r <= '0;
    end else if (tick_s && found_s) begin
      idx_r <= next_idx_s;
    end else begin
      idx_r <= idx_r;
    end
  end

  // Wrap flags the tick whose step lands at or before the current index.
  always_comb begin
    wrap_s = 1'b0;
    if (tick_s && found_s && (next_idx_s <= idx_r)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end
  end

  // Active-low anode decode; a masked current digit stays blank.
  always_comb begin
    anode_s = SCAN_ANODE_IDLE[DIGITS-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if ((IDX_W'(i) == idx_r) && digit_mask[i]) begin
        anode_s[i] = 1'b0;
      end else begin
        anode_s[i] = 1'b1;
      end
    end
  end

  assign tick      = tick_s;
  assign wrap      = wrap_s;
  assign digit_idx = idx_r;
  assign anode     = anode_s;

  anode_scanner_chk #(
    .DIGITS (DIGITS)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .tick  (tick_s),
    .wrap  (wrap_s),
    .anode (anode_s)
  );

endmodule

// File: tb/tb_anode_scanner.sv
// Self-checking bench for anode_scanner. Expected outputs are pushed to a
// queue as each cycle's stimulus is driven and popped/compared on the
// falling edge. The default period is shortened so a full rotation fits in
// a short run.
module tb_anode_scanner;

  localparam int P0 = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        div_load = 1'b0;
  logic [17:0] div_value = 18'd0;
  logic [7:0]  digit_mask = 8'hFF;
  logic        tick;
  logic        wrap;
  logic [2:0]  digit_idx;
  logic [7:0]  anode;

  typedef struct {
    logic       tick;
    logic       wrap;
    logic [2:0] idx;
    logic [7:0] anode;
    string      nm;
  } exp_t;

  typedef struct {
    logic       en;
    logic       ld;
    logic [17:0] val;
    logic [7:0] mask;
    logic       tick;
    logic       wrap;
    logic [2:0] idx;
    logic [7:0] anode;
  } vec_t;

  exp_t q[$];
  vec_t vt[17];
  int   errors = 0;
  int   checks = 0;

  anode_scanner #(
    .DIV_DEFAULT (P0),
    .DIV_W       (18),
    .DIGITS      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_load   (div_load),
    .div_value  (div_value),
    .digit_mask (digit_mask),
    .tick       (tick),
    .wrap       (wrap),
    .digit_idx  (digit_idx),
    .anode      (anode)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] an(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  task automatic expect_out(input logic t, input logic w, input logic [2:0] i,
                            input logic [7:0] a, input string nm);
    exp_t e;
    e.tick = t; e.wrap = w; e.idx = i; e.anode = a; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      e = q.pop_front();
      if (tick !== e.tick || wrap !== e.wrap || digit_idx !== e.idx || anode !== e.anode) begin
        errors++;
        $display("FAIL %s: got tick=%b wrap=%b idx=%0d anode=%h, want tick=%b wrap=%b idx=%0d anode=%h",
                 e.nm, tick, wrap, digit_idx, anode, e.tick, e.wrap, e.idx, e.anode);
      end
    end
  endtask

  // Drive one cycle of inputs, record the expectation, check mid-cycle.
  task automatic cyc(input logic e, input logic ld, input logic [17:0] v, input logic [7:0] m,
                     input logic t, input logic w, input logic [2:0] i, input logic [7:0] a,
                     input string nm);
    en = e; div_load = ld; div_value = v; digit_mask = m;
    expect_out(t, w, i, a, nm);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          en    ld    val     mask   tick  wrap  idx   anode
    vt[0]  = '{1'b1, 1'b1, 18'd3, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hFE};
    vt[1]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hFE};
    vt[2]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hFE};
    vt[3]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b1, 1'b0, 3'd0, 8'hFE};
    vt[4]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd2, 8'hFB};
    vt[5]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd2, 8'hFB};
    vt[6]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b1, 1'b0, 3'd2, 8'hFB};
    vt[7]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd5, 8'hDF};
    vt[8]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd5, 8'hDF};
    vt[9]  = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b1, 1'b0, 3'd5, 8'hDF};
    vt[10] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd7, 8'h7F};
    vt[11] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd7, 8'h7F};
    vt[12] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b1, 1'b1, 3'd7, 8'h7F};
    vt[13] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hFE};
    vt[14] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hFE};
    vt[15] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b1, 1'b0, 3'd0, 8'hFE};
    vt[16] = '{1'b1, 1'b0, 18'd0, 8'hA5, 1'b0, 1'b0, 3'd2, 8'hFB};

    // Reset values, with digit 0 masked and then enabled.
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1; digit_mask = 8'hFE;
    #2;
    expect_out(1'b0, 1'b0, 3'd0, 8'hFF, "rst_digit0_masked"); check_out();
    digit_mask = 8'hFF;
    #1;
    expect_out(1'b0, 1'b0, 3'd0, 8'hFE, "rst_values"); check_out();
    @(posedge clk); #1;
    rst = 1'b1;

    // Default period, full mask: first tick on cycle P0, wrap only on 7->0.
    for (int d = 0; d < 8; d++) begin
      for (int n = 1; n <= P0; n++) begin
        cyc(1'b1, 1'b0, 18'd0, 8'hFF, (n == P0), (n == P0) && (d == 7), 3'(d), an(d), "scan_default");
      end
    end
    cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'hFE, "scan_wrapped");

    // Load period 4 exactly where the old period would tick: no stale tick.
    for (int n = 1; n <= P0 - 2; n++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd0, 8'hFE, "old_period");
    end
    cyc(1'b1, 1'b1, 18'd4, 8'hFF, 1'b0, 1'b0, 3'd0, 8'hFE, "load_no_stale");
    for (int k = 0; k < 3; k++) begin
      for (int n = 1; n <= 4; n++) begin
        cyc(1'b1, 1'b0, 18'd0, 8'hFF, (n == 4), 1'b0, 3'(k), an(k), "period4");
      end
    end

    // Load 0 clamps to 1: tick every cycle.
    cyc(1'b1, 1'b1, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd3, an(3), "load_zero");
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b1, ((3 + k) % 8) == 7, 3'((3 + k) % 8), an((3 + k) % 8), "period1");
    end

    // Sparse mask, period 3, table-driven from a fresh reset.
    rst = 1'b0; digit_mask = 8'hA5;
    #2;
    expect_out(1'b0, 1'b0, 3'd0, 8'hFE, "rst_sparse"); check_out();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int r = 0; r < 17; r++) begin
      cyc(vt[r].en, vt[r].ld, vt[r].val, vt[r].mask, vt[r].tick, vt[r].wrap, vt[r].idx, vt[r].anode, "table_sparse");
    end

    // Empty mask: all blank, index frozen, tick continues, no wrap.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'h00, (k % 3) == 1, 1'b0, 3'd2, 8'hFF, "mask_empty");
    end

    // Single digit 4: first tick moves there, every later tick wraps.
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b0, 1'b0, 3'd2, 8'hFF, "mask10_blank");
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b1, 1'b0, 3'd2, 8'hFF, "mask10_first");
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'h10, (k % 3) == 2, (k % 3) == 2, 3'd4, 8'hEF, "mask10_wrap");
    end

    // Enable low for 10 cycles with cnt=2, per=4.
    cyc(1'b1, 1'b1, 18'd4, 8'h10, 1'b0, 1'b0, 3'd4, 8'hEF, "load4");
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b0, 1'b0, 3'd4, 8'hEF, "en_pre");
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b0, 1'b0, 3'd4, 8'hEF, "en_pre");
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 18'd0, 8'h10, 1'b0, 1'b0, 3'd4, 8'hEF, "en_low");
    end
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b0, 1'b0, 3'd4, 8'hEF, "en_resume");
    cyc(1'b1, 1'b0, 18'd0, 8'h10, 1'b1, 1'b1, 3'd4, 8'hEF, "en_resume_tick");

    // Step to index 5, with enable dropped exactly at terminal count.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd4, 8'hEF, "pre_idx5");
    end
    cyc(1'b0, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd4, 8'hEF, "en_low_terminal");
    cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b1, 1'b0, 3'd4, 8'hEF, "to_idx5");
    cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd5, 8'hDF, "idx5");
    cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd5, 8'hDF, "idx5");

    // Asynchronous reset mid-period, checked before the next clock edge.
    rst = 1'b0;
    #2;
    expect_out(1'b0, 1'b0, 3'd0, 8'hFE, "async_reset"); check_out();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int n = 1; n <= P0; n++) begin
      cyc(1'b1, 1'b0, 18'd0, 8'hFF, (n == P0), 1'b0, 3'd0, 8'hFE, "post_reset");
    end
    cyc(1'b1, 1'b0, 18'd0, 8'hFF, 1'b0, 1'b0, 3'd1, 8'hFD, "post_reset_idx1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
